// File: rtl/pwdata_serializer_if.sv
// Bundle between the bridge FSM (master) and the write-data serializer (slave).
// Carries the capture request, the APB beat handshake and the serializer status.
interface pwdata_serializer_if #(
  parameter int AHB_DW = 32,
  parameter int APB_DW = 8
);
  localparam int RATIO = AHB_DW / APB_DW;

  function automatic int cw_of(input int ratio);
    int r;
    r = 1;
    while ((1 << r) < ratio) r++;
    return r;
  endfunction

  localparam int CW = cw_of(RATIO);

  logic [AHB_DW-1:0] i_HWDATA;
  logic              i_start;
  logic [CW-1:0]     i_offset;
  logic [CW:0]       i_beats;
  logic              i_next;
  logic [APB_DW-1:0] o_PWDATA;
  logic              o_busy;
  logic              o_last;
  logic              o_done;
  logic              dbg_state;

  modport master (
    output i_HWDATA, i_start, i_offset, i_beats, i_next,
    input  o_PWDATA, o_busy, o_last, o_done, dbg_state
  );

  modport slave (
    input  i_HWDATA, i_start, i_offset, i_beats, i_next,
    output o_PWDATA, o_busy, o_last, o_done, dbg_state
  );
endinterface

// File: rtl/pwdata_serializer.sv
// Captures one AHB write word and presents it to APB as APB_DW-wide beats,
// starting at the addressed chunk and wrapping modulo RATIO.
module pwdata_serializer #(
  parameter int AHB_DW = 32,
  parameter int APB_DW = 8
) (
  input logic clk,
  input logic rst,
  pwdata_serializer_if.slave bus
);
  localparam int RATIO = AHB_DW / APB_DW;

  function automatic int cw_of(input int ratio);
    int r;
    r = 1;
    while ((1 << r) < ratio) r++;
    return r;
  endfunction

  localparam int CW = cw_of(RATIO);
  localparam logic [CW:0]   RATIO_W = (CW+1)'(RATIO);
  localparam logic [CW-1:0] IDX_MAX = CW'(RATIO - 1);

  // Handshake: i_start is taken only in IDLE with i_beats != 0; each i_next
  // in SEND retires the presented beat; o_done pulses the cycle after the last.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state;
  logic [AHB_DW-1:0] data_q;
  logic [CW-1:0]     idx;
  logic [CW:0]       rem;
  logic              busy_q;
  logic              last_q;
  logic              done_q;

  logic [CW:0]       beats_clamped;
  logic [CW-1:0]     idx_inc;
  logic [APB_DW-1:0] chunk;

  always_comb begin
    beats_clamped = (bus.i_beats > RATIO_W) ? RATIO_W : bus.i_beats;
    idx_inc       = (idx == IDX_MAX) ? '0 : idx + CW'(1);
  end

  // Explicit mux keeps the select in range even for non-power-of-2 RATIO.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == CW'(i)) chunk = data_q[i*APB_DW +: APB_DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      idx    <= '0;
      rem    <= '0;
      busy_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start && (bus.i_beats != '0)) begin
            data_q <= bus.i_HWDATA;
            idx    <= bus.i_offset;
            rem    <= beats_clamped;
            busy_q <= 1'b1;
            last_q <= (beats_clamped == (CW+1)'(1));
            state  <= SEND;
          end
        end
        SEND: begin
          if (bus.i_next) begin
            if (rem > (CW+1)'(1)) begin
              idx    <= idx_inc;
              rem    <= rem - (CW+1)'(1);
              last_q <= (rem == (CW+1)'(2));
            end else begin
              rem    <= '0;
              busy_q <= 1'b0;
              last_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_PWDATA  = chunk;
  assign bus.o_busy    = busy_q;
  assign bus.o_last    = last_q;
  assign bus.o_done    = done_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_pwdata_serializer.sv
// Directed bench for pwdata_serializer with AHB_DW=32, APB_DW=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_pwdata_serializer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];

  pwdata_serializer_if #(.AHB_DW(32), .APB_DW(8)) bus ();

  pwdata_serializer #(.AHB_DW(32), .APB_DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic start_word(input logic [31:0] d, input logic [1:0] off, input logic [2:0] beats);
    bus.i_HWDATA = d;
    bus.i_offset = off;
    bus.i_beats  = beats;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
  endtask

  // Retires n queued beats with i_next high; ends on the done cycle.
  task automatic run_beats(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk("pwdata", 32'(bus.o_PWDATA), 32'(e));
      chk("last", 32'(bus.o_last), 32'(i == n - 1));
      chk("busy", 32'(bus.o_busy), 32'd1);
      bus.i_next = 1'b1;
      @(negedge clk);
    end
    bus.i_next = 1'b0;
    chk("done_pulse", 32'(bus.o_done), 32'd1);
    chk("busy_after", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic idle_step();
    @(negedge clk);
    chk("done_clear", 32'(bus.o_done), 32'd0);
    chk("busy_idle", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.i_HWDATA = '0;
    bus.i_start  = 1'b0;
    bus.i_offset = '0;
    bus.i_beats  = '0;
    bus.i_next   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pwdata", 32'(bus.o_PWDATA), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_last", 32'(bus.o_last), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // full word, offset 0
    exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    start_word(32'hA1B2C3D4, 2'd0, 3'd4);
    run_beats(4);
    idle_step();
    chk("idle_hold", 32'(bus.o_PWDATA), 32'hA1);

    // partial, offset 2
    exp_q = '{8'hB2, 8'hA1};
    start_word(32'hA1B2C3D4, 2'd2, 3'd2);
    run_beats(2);
    idle_step();

    // wrap-around from offset 3
    exp_q = '{8'hA1, 8'hD4};
    start_word(32'hA1B2C3D4, 2'd3, 3'd2);
    run_beats(2);
    idle_step();

    // beat count above RATIO clamps to 4, offset 1 wraps
    exp_q = '{8'hC3, 8'hB2, 8'hA1, 8'hD4};
    start_word(32'hA1B2C3D4, 2'd1, 3'd7);
    run_beats(4);
    idle_step();

    // wait states with an ignored start during SEND
    start_word(32'hA1B2C3D4, 2'd0, 3'd4);
    chk("ws_b0", 32'(bus.o_PWDATA), 32'hD4);
    bus.i_next = 1'b1;
    @(negedge clk);
    bus.i_next = 1'b0;
    bus.i_HWDATA = 32'hFFFFFFFF;
    bus.i_offset = 2'd0;
    bus.i_beats  = 3'd4;
    bus.i_start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ws_hold", 32'(bus.o_PWDATA), 32'hC3);
      chk("ws_busy", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    exp_q = '{8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 3; i++) begin
      chk("ws_pwdata", 32'(bus.o_PWDATA), 32'(exp_q.pop_front()));
      chk("ws_last", 32'(bus.o_last), 32'(i == 2));
      bus.i_next = 1'b1;
      @(negedge clk);
    end
    bus.i_next = 1'b0;
    chk("ws_done", 32'(bus.o_done), 32'd1);

    // back-to-back: start accepted in the done cycle
    exp_q = '{8'h33};
    start_word(32'h11223344, 2'd1, 3'd1);
    chk("b2b_busy", 32'(bus.o_busy), 32'd1);
    run_beats(1);
    idle_step();

    // asynchronous reset after beat 2
    start_word(32'hA1B2C3D4, 2'd0, 3'd4);
    bus.i_next = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_next = 1'b0;
    chk("pre_rst_pwdata", 32'(bus.o_PWDATA), 32'hB2);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwdata", 32'(bus.o_PWDATA), 32'h0);
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_last", 32'(bus.o_last), 32'd0);
    chk("arst_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_next = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
      chk("post_rst_done", 32'(bus.o_done), 32'd0);
      chk("post_rst_pwdata", 32'(bus.o_PWDATA), 32'h0);
    end
    bus.i_next = 1'b0;

    // zero-beat start is ignored
    start_word(32'h55AA55AA, 2'd0, 3'd0);
    chk("zero_busy", 32'(bus.o_busy), 32'd0);
    chk("zero_pwdata", 32'(bus.o_PWDATA), 32'h0);
    chk("zero_state", 32'(bus.dbg_state), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwdata_serializer.md
Name: pwdata_serializer

Overview:
- Write-path counterpart of the bridge's read-data assembly register.
- Captures one AHB write data word (HWDATA, AHB_DW bits) and delivers it to the APB side as a sequence of APB_DW-wide PWDATA beats, lowest selected chunk first.
- Advances one beat per completed APB transfer, as signalled by the bridge FSM.
- Sits between the AHB slave interface and the APB master FSM inside ahb_to_apb_module.

Parameters:
- AHB_DW, 32: AHB data width; integer multiple of APB_DW.
- APB_DW, 8: APB data width.
- Derived localparam RATIO = AHB_DW/APB_DW.
- Derived localparam CW = max(1, ceil(log2(RATIO))), computed with a constant function.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- i_HWDATA  input  AHB_DW  AHB write data; sampled only on an accepted i_start.
- i_start  input  1  capture request from the bridge FSM (data phase of an AHB write).
- i_offset  input  CW  index of the first chunk to send (from HADDR low bits).
- i_beats  input  CW+1  number of APB beats to send, 1..RATIO.
- i_next  input  1  current beat accepted on APB (PSEL & PENABLE & PREADY).
- o_PWDATA  output  APB_DW  chunk currently presented to APB.
- o_busy  output  1  serializer holds beats not yet accepted.
- o_last  output  1  current beat is the final one.
- o_done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE; data register, index, remaining count, o_PWDATA, o_done all 0; o_busy=0; o_last=0. Applies immediately, including mid-transfer; pending beats are discarded.
- States: IDLE and SEND.
- IDLE, i_start=1 and i_beats!=0:
  - Next edge: data_q<=i_HWDATA, idx<=i_offset, rem<=min(i_beats,RATIO); go to SEND.
  - i_beats=0: start is ignored; stay IDLE.
  - i_beats>RATIO: clamped to RATIO.
- SEND:
  - o_PWDATA = data_q[idx*APB_DW +: APB_DW]; combinational from registers, so it is valid the cycle after i_start (latency 1).
  - o_busy=1.
  - o_last = (rem==1).
- SEND, i_next=1 and rem>1: idx<=(idx+1) mod RATIO (wrap-around), rem<=rem-1.
- SEND, i_next=1 and rem==1: go to IDLE; o_done=1 for exactly the next cycle.
- SEND, i_next=0: all state holds; o_PWDATA stable (APB requires PWDATA stable during wait states).
- i_start while in SEND: ignored; the captured word is not overwritten.
- i_next while in IDLE: ignored.
- o_done cycle: state is already IDLE, so i_start is accepted in that same cycle. Back-to-back words therefore have no dead cycle beyond the done cycle.
- IDLE output: o_PWDATA keeps presenting data_q at idx, i.e. the last chunk sent. It is 0 after reset.
- RATIO=1: CW=1, idx is always 0, every transfer is a single beat, o_last=1 whenever busy.
- Width rules:
  - idx arithmetic is modulo RATIO; for non-power-of-2 RATIO, idx==RATIO-1 wraps explicitly to 0.
  - rem is CW+1 bits and never underflows.

Test Plan:
- AHB_DW=32, APB_DW=8. i_HWDATA=0xA1B2C3D4, i_offset=0, i_beats=4, i_next held high -> o_PWDATA sequence D4,C3,B2,A1 on consecutive cycles; o_last high on A1; o_done pulse one cycle later; o_busy high for exactly 4 cycles.
- Same word, i_offset=2, i_beats=2 -> B2 then A1.
- Same word, i_offset=3, i_beats=2 -> A1 then D4 (wrap-around); o_done after the 2nd i_next.
- Wait states: i_next low 3 cycles between beats -> o_PWDATA held stable and o_busy=1 throughout; a second i_start with 0xFFFFFFFF during SEND is ignored, later beats still come from 0xA1B2C3D4.
- Back-to-back: i_start asserted in the o_done cycle with 0x11223344, i_beats=1, i_offset=1 -> accepted; next cycle o_PWDATA=0x33, o_last=1.
- Reset mid-transfer: rst asserted asynchronously after beat 2 -> outputs go to 0 without waiting for a clock edge, state IDLE; i_next after release causes no activity; i_beats=0 start is ignored.
